// File: rtl/mult_dot_sequencer.sv
// Operand sequencer and product accumulator for the 16-bit sequential
// multiplier. Issues one (a, b) pair at a time, accumulates each product
// and presents the dot-product sum, term count and status flags on a
// valid/ready result port once the pair marked last has completed.
module mult_dot_sequencer #(
    parameter int unsigned ACC_W   = 40,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    input  logic             op_last,
    output logic             mul_start,
    output logic [15:0]      mul_ain,
    output logic [15:0]      mul_bin,
    input  logic [31:0]      mul_yout,
    input  logic             mul_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_sum,
    output logic [7:0]       res_count,
    output logic             res_ovf,
    output logic             res_err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN,
        S_RESULT
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        ain_q, ain_d;
    logic [15:0]        bin_q, bin_d;
    logic               last_q, last_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [ACC_W:0]     sum_ext;

    // One extra bit on the adder exposes the carry out of the accumulator.
    assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - 32){1'b0}}, mul_yout};

    // Next-state and datapath updates; every target defaults to hold.
    always_comb begin
        state_d = state_q;
        ain_d   = ain_q;
        bin_d   = bin_q;
        last_d  = last_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        tmo_d   = tmo_q;

        unique case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    ain_d   = op_a;
                    bin_d   = op_b;
                    last_d  = op_last;
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mul_done) begin
                    acc_d = sum_ext[ACC_W-1:0];
                    if (sum_ext[ACC_W]) begin
                        ovf_d = 1'b1;
                    end
                    state_d = S_DRAIN;
                end else if (tmo_q == TMO_LAST) begin
                    // Timed-out term is counted but never added.
                    err_d   = 1'b1;
                    state_d = S_DRAIN;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Let the multiplier return to idle before the next start.
                if (!mul_done) begin
                    state_d = last_q ? S_RESULT : S_IDLE;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ain_q   <= '0;
            bin_q   <= '0;
            last_q  <= 1'b0;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            ain_q   <= ain_d;
            bin_q   <= bin_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // Handshake outputs decode the registered state, so an asynchronous
    // reset removes mul_start and res_valid without waiting for a clock;
    // op_ready is additionally held low while reset is asserted.
    assign op_ready  = (state_q == S_IDLE) && !rst;
    assign mul_start = (state_q == S_WAIT);
    assign res_valid = (state_q == S_RESULT);
    assign mul_ain   = ain_q;
    assign mul_bin   = bin_q;
    assign res_sum   = acc_q;
    assign res_count = count_q;
    assign res_ovf   = ovf_q;
    assign res_err   = err_q;

endmodule

// File: tb/tb_mult_dot_sequencer.sv
// Self-checking bench: two sequencer instances (default widths, and a
// 32-bit accumulator with TIMEOUT=8), each driving a behavioural multiplier.
module tb_mult_dot_sequencer;

    localparam int LAT_A = 17;
    localparam int LAT_B = 3;
    localparam int TMO_A = 64;
    localparam int TMO_B = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: ACC_W=40, TIMEOUT=64
    logic        a_rst, a_op_valid, a_op_ready, a_op_last;
    logic [15:0] a_op_a, a_op_b, a_mul_ain, a_mul_bin;
    logic        a_mul_start, a_res_valid, a_res_ready, a_res_ovf, a_res_err;
    logic        a_mul_done = 1'b0;
    logic [31:0] a_mul_yout = '0;
    logic [39:0] a_res_sum;
    logic [7:0]  a_res_count;
    logic        a_hang = 1'b0;
    int          a_cnt = 0;

    // Instance B: ACC_W=32, TIMEOUT=8
    logic        b_rst, b_op_valid, b_op_ready, b_op_last;
    logic [15:0] b_op_a, b_op_b, b_mul_ain, b_mul_bin;
    logic        b_mul_start, b_res_valid, b_res_ready, b_res_ovf, b_res_err;
    logic        b_mul_done = 1'b0;
    logic [31:0] b_mul_yout = '0;
    logic [31:0] b_res_sum;
    logic [7:0]  b_res_count;
    logic        b_hang = 1'b0;
    int          b_cnt = 0;

    mult_dot_sequencer #(.ACC_W(40), .TIMEOUT(TMO_A)) dut_a (
        .clk(clk), .rst(a_rst),
        .op_valid(a_op_valid), .op_ready(a_op_ready),
        .op_a(a_op_a), .op_b(a_op_b), .op_last(a_op_last),
        .mul_start(a_mul_start), .mul_ain(a_mul_ain), .mul_bin(a_mul_bin),
        .mul_yout(a_mul_yout), .mul_done(a_mul_done),
        .res_valid(a_res_valid), .res_ready(a_res_ready),
        .res_sum(a_res_sum), .res_count(a_res_count),
        .res_ovf(a_res_ovf), .res_err(a_res_err)
    );

    mult_dot_sequencer #(.ACC_W(32), .TIMEOUT(TMO_B)) dut_b (
        .clk(clk), .rst(b_rst),
        .op_valid(b_op_valid), .op_ready(b_op_ready),
        .op_a(b_op_a), .op_b(b_op_b), .op_last(b_op_last),
        .mul_start(b_mul_start), .mul_ain(b_mul_ain), .mul_bin(b_mul_bin),
        .mul_yout(b_mul_yout), .mul_done(b_mul_done),
        .res_valid(b_res_valid), .res_ready(b_res_ready),
        .res_sum(b_res_sum), .res_count(b_res_count),
        .res_ovf(b_res_ovf), .res_err(b_res_err)
    );

    // Behavioural multipliers: done rises LAT cycles after start is seen,
    // stays high while start is high, falls the cycle after start drops.
    always @(posedge clk) begin
        if (!a_mul_start) begin
            a_cnt      <= 0;
            a_mul_done <= 1'b0;
        end else if (!a_mul_done && !a_hang) begin
            if (a_cnt == LAT_A - 1) begin
                a_mul_done <= 1'b1;
                a_mul_yout <= 32'(a_mul_ain) * 32'(a_mul_bin);
            end else begin
                a_cnt <= a_cnt + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (!b_mul_start) begin
            b_cnt      <= 0;
            b_mul_done <= 1'b0;
        end else if (!b_mul_done && !b_hang) begin
            if (b_cnt == LAT_B - 1) begin
                b_mul_done <= 1'b1;
                b_mul_yout <= 32'(b_mul_ain) * 32'(b_mul_bin);
            end else begin
                b_cnt <= b_cnt + 1;
            end
        end
    end

    typedef struct {
        int               sel;
        int               n;
        logic [2:0][15:0] a;
        logic [2:0][15:0] b;
        int               hang_idx;
        logic [39:0]      sum;
        logic [7:0]       cnt;
        logic             ovf;
        logic             err;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[6];

    function automatic vec_t mk(input int sel, input int n,
                                input logic [15:0] a0, input logic [15:0] b0,
                                input logic [15:0] a1, input logic [15:0] b1,
                                input logic [15:0] a2, input logic [15:0] b2,
                                input int hang_idx, input logic [39:0] sum,
                                input logic [7:0] cnt, input logic ovf, input logic err);
        vec_t v;
        v.sel = sel; v.n = n;
        v.a[0] = a0; v.b[0] = b0; v.a[1] = a1; v.b[1] = b1; v.a[2] = a2; v.b[2] = b2;
        v.hang_idx = hang_idx; v.sum = sum; v.cnt = cnt; v.ovf = ovf; v.err = err;
        return v;
    endfunction

    function automatic logic g_ready(input int s);
        return (s == 0) ? a_op_ready : b_op_ready;
    endfunction
    function automatic logic g_start(input int s);
        return (s == 0) ? a_mul_start : b_mul_start;
    endfunction
    function automatic logic g_valid(input int s);
        return (s == 0) ? a_res_valid : b_res_valid;
    endfunction
    function automatic logic [39:0] g_sum(input int s);
        return (s == 0) ? a_res_sum : {8'h00, b_res_sum};
    endfunction
    function automatic logic [7:0] g_count(input int s);
        return (s == 0) ? a_res_count : b_res_count;
    endfunction
    function automatic logic g_ovf(input int s);
        return (s == 0) ? a_res_ovf : b_res_ovf;
    endfunction
    function automatic logic g_err(input int s);
        return (s == 0) ? a_res_err : b_res_err;
    endfunction
    function automatic logic [15:0] g_ain(input int s);
        return (s == 0) ? a_mul_ain : b_mul_ain;
    endfunction
    function automatic logic [15:0] g_bin(input int s);
        return (s == 0) ? a_mul_bin : b_mul_bin;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input int s, input logic v, input logic [15:0] a,
                            input logic [15:0] b, input logic last);
        if (s == 0) begin
            a_op_valid = v; a_op_a = a; a_op_b = b; a_op_last = last;
        end else begin
            b_op_valid = v; b_op_a = a; b_op_b = b; b_op_last = last;
        end
    endtask

    task automatic set_rready(input int s, input logic v);
        if (s == 0) a_res_ready = v; else b_res_ready = v;
    endtask

    task automatic set_hang(input int s, input logic v);
        if (s == 0) a_hang = v; else b_hang = v;
    endtask

    // Present a pair until it is accepted, then withdraw it.
    task automatic send(input int s, input logic [15:0] a, input logic [15:0] b, input logic last);
        logic rdy;
        logic accepted = 1'b0;
        drive_op(s, 1'b1, a, b, last);
        for (int i = 0; i < 500; i++) begin
            rdy = g_ready(s);
            tick();
            if (rdy) begin
                accepted = 1'b1;
                break;
            end
        end
        drive_op(s, 1'b0, '0, '0, 1'b0);
        check("op_accept", 64'(accepted), 64'd1);
    endtask

    // Count sampled cycles with mul_start high.
    task automatic start_width(input int s, output int w);
        w = 0;
        while (g_start(s) && w < 300) begin
            w++;
            tick();
        end
    endtask

    task automatic wait_result(input int s);
        logic seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (g_valid(s)) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("res_valid_seen", 64'(seen), 64'd1);
    endtask

    task automatic handshake(input int s);
        set_rready(s, 1'b1);
        tick();
        set_rready(s, 1'b0);
        check("res_valid_drop", 64'(g_valid(s)), 64'd0);
        check("op_ready_after_res", 64'(g_ready(s)), 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int w;
        int lat;
        int tmo;
        lat = (v.sel == 0) ? LAT_A : LAT_B;
        tmo = (v.sel == 0) ? TMO_A : TMO_B;
        for (int i = 0; i < v.n; i++) begin
            set_hang(v.sel, i == v.hang_idx);
            send(v.sel, v.a[i], v.b[i], i == v.n - 1);
            check("start_after_accept", 64'(g_start(v.sel)), 64'd1);
            check("mul_ain", 64'(g_ain(v.sel)), 64'(v.a[i]));
            check("mul_bin", 64'(g_bin(v.sel)), 64'(v.b[i]));
            start_width(v.sel, w);
            check("start_width", 64'(w), (i == v.hang_idx) ? 64'(tmo) : 64'(lat + 1));
            set_hang(v.sel, 1'b0);
        end
        wait_result(v.sel);
        check("res_sum", 64'(g_sum(v.sel)), 64'(v.sum));
        check("res_count", 64'(g_count(v.sel)), 64'(v.cnt));
        check("res_ovf", 64'(g_ovf(v.sel)), 64'(v.ovf));
        check("res_err", 64'(g_err(v.sel)), 64'(v.err));
        handshake(v.sel);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        vecs[0] = mk(0, 1, 16'd3, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0, -1, 40'd15, 8'd1, 1'b0, 1'b0);
        vecs[1] = mk(0, 3, 16'h0010, 16'h0020, 16'hFFFF, 16'h0002, 16'd7, 16'd9, -1,
                     40'h2023D, 8'd3, 1'b0, 1'b0);
        vecs[2] = mk(0, 1, 16'd0, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, -1, 40'd0, 8'd1, 1'b0, 1'b0);
        vecs[3] = mk(1, 2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, -1,
                     40'hFFFC0002, 8'd2, 1'b1, 1'b0);
        vecs[4] = mk(1, 3, 16'd1, 16'd2, 16'd1, 16'd3, 16'd1, 16'd4, 1, 40'd6, 8'd3, 1'b0, 1'b1);
        vecs[5] = mk(1, 1, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, -1,
                     40'hFFFE0001, 8'd1, 1'b0, 1'b0);

        a_rst = 1'b1; b_rst = 1'b1;
        a_res_ready = 1'b0; b_res_ready = 1'b0;
        drive_op(0, 1'b0, '0, '0, 1'b0);
        drive_op(1, 1'b0, '0, '0, 1'b0);
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            check("rst_op_ready", 64'(g_ready(s)), 64'd0);
            check("rst_mul_start", 64'(g_start(s)), 64'd0);
            check("rst_res_valid", 64'(g_valid(s)), 64'd0);
            check("rst_res_sum", 64'(g_sum(s)), 64'd0);
            check("rst_res_count", 64'(g_count(s)), 64'd0);
        end
        a_rst = 1'b0; b_rst = 1'b0;
        tick();
        check("post_rst_ready_a", 64'(a_op_ready), 64'd1);
        check("post_rst_ready_b", 64'(b_op_ready), 64'd1);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: result held while the next pair waits upstream.
        send(0, 16'd6, 16'd7, 1'b1);
        start_width(0, w);
        wait_result(0);
        drive_op(0, 1'b1, 16'd2, 16'd2, 1'b1);
        for (int i = 0; i < 20; i++) begin
            check("bp_res_valid", 64'(a_res_valid), 64'd1);
            check("bp_op_ready", 64'(a_op_ready), 64'd0);
            check("bp_res_sum", 64'(a_res_sum), 64'd42);
            check("bp_res_count", 64'(a_res_count), 64'd1);
            check("bp_mul_start", 64'(a_mul_start), 64'd0);
            tick();
        end
        set_rready(0, 1'b1);
        tick();
        set_rready(0, 1'b0);
        check("bp_valid_drop", 64'(a_res_valid), 64'd0);
        check("bp_ready_rise", 64'(a_op_ready), 64'd1);
        check("bp_acc_clear", 64'(a_res_sum), 64'd0);
        check("bp_count_clear", 64'(a_res_count), 64'd0);
        tick();
        check("bp_next_accept", 64'(a_mul_start), 64'd1);
        drive_op(0, 1'b0, '0, '0, 1'b0);
        start_width(0, w);
        check("bp_next_width", 64'(w), 64'(LAT_A + 1));
        wait_result(0);
        check("bp_next_sum", 64'(a_res_sum), 64'd4);
        check("bp_next_count", 64'(a_res_count), 64'd1);
        handshake(0);

        // res_ready held before res_valid: result consumed in its first cycle.
        set_rready(1, 1'b1);
        send(1, 16'd5, 16'd6, 1'b1);
        start_width(1, w);
        wait_result(1);
        check("pre_ready_sum", 64'(b_res_sum), 64'd30);
        check("pre_ready_count", 64'(b_res_count), 64'd1);
        tick();
        check("pre_ready_valid_drop", 64'(b_res_valid), 64'd0);
        check("pre_ready_op_ready", 64'(b_op_ready), 64'd1);
        set_rready(1, 1'b0);

        // Term count saturates at 255.
        for (int i = 0; i < 256; i++) begin
            send(1, 16'd0, 16'd0, i == 255);
            start_width(1, w);
        end
        wait_result(1);
        check("sat_count", 64'(b_res_count), 64'd255);
        check("sat_sum", 64'(b_res_sum), 64'd0);
        handshake(1);

        // Reset asserted between edges while waiting on the multiplier.
        send(0, 16'd9, 16'd9, 1'b1);
        tick();
        tick();
        check("mid_wait_start", 64'(a_mul_start), 64'd1);
        #3;
        a_rst = 1'b1;
        #1;
        check("mid_rst_start", 64'(a_mul_start), 64'd0);
        check("mid_rst_valid", 64'(a_res_valid), 64'd0);
        tick();
        tick();
        a_rst = 1'b0;
        tick();
        check("mid_rst_ready", 64'(a_op_ready), 64'd1);
        check("mid_rst_count", 64'(a_res_count), 64'd0);
        run_vec(mk(0, 1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, -1, 40'd1, 8'd1, 1'b0, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_dot_sequencer.md
# mult_dot_sequencer

Operand sequencer and product accumulator for the 16-bit sequential multiplier. It accepts a stream of (a, b) operand pairs and drives the multiplier's start/ain/bin handshake one pair at a time. On each done it captures the 32-bit product and accumulates it. When the pair marked last completes, it presents the dot-product sum, term count and status on a valid/ready result port.

## Interface
- ACC_W, 40: accumulator and result width (≥ 32); sum wraps modulo 2^ACC_W.
- TIMEOUT, 64: max cycles to wait for mul_done after issuing start; must be ≥ 2.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  sequencer can accept a pair.
- op_a  in  16  multiplicand.
- op_b  in  16  multiplier.
- op_last  in  1  final pair of the current dot product.
- mul_start  out  1  start to multiplier; held high until done is seen.
- mul_ain  out  16  registered operand a to multiplier.
- mul_bin  out  16  registered operand b to multiplier.
- mul_yout  in  32  multiplier product.
- mul_done  in  1  multiplier done (level; stays high while start is high).
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_sum  out  ACC_W  accumulated sum.
- res_count  out  8  number of terms accepted, saturating at 255.
- res_ovf  out  1  sum wrapped at least once.
- res_err  out  1  at least one term timed out; that term is not added.

## Operation
- Reset: all outputs 0, acc/count/flags cleared, state IDLE. Reset asserted mid-operation drops mul_start immediately, without waiting for a clock edge.
- IDLE: op_ready=1.
  - On op_valid&op_ready: register op_a/op_b into mul_ain/mul_bin, latch op_last, count += 1 (saturate at 255), set mul_start=1, go WAIT.
- WAIT: op_ready=0, mul_start=1, timeout counter increments each cycle.
  - mul_done sampled 1: acc ← acc + zero-extended mul_yout. If the add carries out of ACC_W, set ovf (sticky). Clear mul_start, go DRAIN.
  - Counter reaches TIMEOUT without done: set err (sticky), clear mul_start, go DRAIN. No add.
- DRAIN: mul_start=0. Wait until mul_done is sampled 0, so the multiplier has returned to idle before the next start.
  - Then go RESULT if the latched last=1, else IDLE.
- RESULT: res_valid=1. res_sum/res_count/res_ovf/res_err are stable and driven from registers.
  - On res_valid&res_ready: clear acc, count, ovf, err; go IDLE.
- mul_ain/mul_bin hold their values from issue until the next accept.
- Products are unsigned; no sign extension.

## Timing
- Accept at edge N → mul_start=1 and operands valid after edge N.
- mul_done first sampled high at edge M → acc updated and mul_start=0 after edge M.
- mul_done sampled low at edge M+k (k ≥ 1) → state IDLE or RESULT after that edge.
  - With an ideal multiplier, done drops the cycle after start drops, so k=1.
- Next op_ready=1 occurs at the earliest 2 cycles after done is seen.
- Result handshake:
  - res_valid rises the cycle after the last term's DRAIN completes.
  - res_valid falls the cycle after res_ready is sampled high.
  - op_ready=1 on that same cycle.
- res_ready held high before res_valid rises is legal; the handshake completes in the first RESULT cycle.
- Timeout: err is set and mul_start drops after the TIMEOUT-th WAIT cycle without done.
- op_valid while op_ready=0 has no effect; the upstream block holds the pair stable.

## Test plan
- Single term, with a behavioural multiplier model (done 17 cycles after start):
  - Stimulus: a=3, b=5, last=1.
  - Required: res_sum=15, res_count=1, ovf=0, err=0.
  - mul_start stays high exactly until the cycle after done.
- Three-term dot product:
  - Stimulus: (0x0010,0x0020), (0xFFFF,0x0002), (7,9) with last on the third pair.
  - Required: res_sum=0x200+0x1FFFE+63=0x2023D, count=3.
- Overflow with ACC_W=32:
  - Stimulus: two terms 0xFFFF×0xFFFF.
  - Required: res_sum=0xFFFC0002, res_ovf=1.
- Timeout with TIMEOUT=8:
  - Stimulus: model never raises done for term 2 of 3 (terms 2,3,4 with last on the third pair).
  - Required: mul_start drops after 8 cycles; res_sum=2+4=6; count=3; res_err=1.
- Backpressure:
  - Stimulus: hold res_ready=0 for 20 cycles with op_valid=1.
  - Required: res_valid and outputs stable; op_ready=0 throughout.
  - Then pulse res_ready: op_ready=1 next cycle and acc cleared (next single term 2×2 gives 4).
- Reset mid-operation:
  - Stimulus: assert rst in WAIT between clock edges.
  - Required: mul_start=0 and res_valid=0 immediately; after release, op_ready=1 and a fresh 1×1 term gives res_sum=1, count=1.
